// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - RV32 data-memory responder with funct3 decode and programmable wait states.
// Optional DMEM_MISALIGN_CHECK_EN: misaligned halfword/word accesses report rsp_err instead of being aligned down.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        req_ready,
  output logic        busy,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          a_write;
  logic [AW+1:0] a_addr;
  logic [31:0]   a_wdata;
  logic [2:0]    a_f3;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          is_byte;
  logic          is_half;
  logic          is_word;
  logic          illegal;
  logic          misal;
  logic          err;
  logic [1:0]    lo;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   ld_data;
  logic [3:0]    be;
  logic [31:0]   wr_data;

  // Bits above the RAM index are dropped so addresses wrap.
  logic addr_unused;
  assign addr_unused = ^req_addr[31:AW+2];

  assign req_ready = (state == S_IDLE);
  assign busy      = ~req_ready;
  assign rsp_valid = (state == S_RESP);
  assign accept    = req_valid & req_ready;

  always_comb begin
    is_byte = (a_f3[1:0] == 2'b00);
    is_half = (a_f3[1:0] == 2'b01);
    is_word = (a_f3 == 3'b010);
    if (a_write) illegal = a_f3[2] | (a_f3 == 3'b011);
    else         illegal = (a_f3 == 3'b011) | (a_f3[2:1] == 2'b11);
    misal = (is_half & a_addr[0]) | (is_word & (a_addr[1:0] != 2'b00));
    lo    = a_addr[1:0];
`ifdef DMEM_MISALIGN_CHECK_EN
    err = illegal | misal;
`else
    err = illegal;
    if (is_half) lo[0] = 1'b0;
    if (is_word) lo    = 2'b00;
`endif
  end

  assign word_idx = a_addr[AW+1:2];
  assign rd_word  = mem[word_idx];
  assign byte_sel = rd_word[{lo, 3'b000} +: 8];
  assign half_sel = lo[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_data = 32'd0;
    if (!a_write && !err) begin
      if (is_byte)      ld_data = {{24{~a_f3[2] & byte_sel[7]}}, byte_sel};
      else if (is_half) ld_data = {{16{~a_f3[2] & half_sel[15]}}, half_sel};
      else if (is_word) ld_data = rd_word;
    end
  end

  always_comb begin
    be      = 4'b0000;
    wr_data = a_wdata;
    if (a_write && !err) begin
      if (is_byte) begin
        be      = 4'b0001 << lo;
        wr_data = {4{a_wdata[7:0]}};
      end else if (is_half) begin
        be      = lo[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{a_wdata[15:0]}};
      end else if (is_word) begin
        be      = 4'b1111;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      a_write   <= 1'b0;
      a_addr    <= '0;
      a_wdata   <= 32'd0;
      a_f3      <= 3'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_write <= req_write;
            a_addr  <= req_addr[AW+1:0];
            a_wdata <= req_wdata;
            a_f3    <= req_funct3;
            cnt     <= WS;
            state   <= (WS != 4'd0) ? S_WAIT : S_ACCESS;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) state <= S_ACCESS;
        end
        S_ACCESS: begin
          rsp_rdata <= ld_data;
          rsp_err   <= err;
          state     <= S_RESP;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM has no reset; an async reset pulls state out of ACCESS, so a pending store never commits.
  always_ff @(posedge clk) begin
    if (state == S_ACCESS) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed-vector bench for dmem_responder at WAIT_STATES 0 and 3.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        rv0, rv3;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rdy0, busy0, rspv0, er0;
  logic [31:0] rd0;
  logic        rdy3, busy3, rspv3, er3;
  logic [31:0] rd3;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(rv0), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .req_ready(rdy0), .busy(busy0), .rsp_valid(rspv0), .rsp_rdata(rd0), .rsp_err(er0)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .reset(reset), .req_valid(rv3), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .req_ready(rdy3), .busy(busy3), .rsp_valid(rspv3), .rsp_rdata(rd3), .rsp_err(er3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic get_busy(input int d);
    return (d == 0) ? busy0 : busy3;
  endfunction
  function automatic logic get_rv(input int d);
    return (d == 0) ? rspv0 : rspv3;
  endfunction
  function automatic logic [31:0] get_rd(input int d);
    return (d == 0) ? rd0 : rd3;
  endfunction
  function automatic logic get_er(input int d);
    return (d == 0) ? er0 : er3;
  endfunction

  task automatic set_valid(input int d, input logic v);
    if (d == 0) rv0 = v;
    else        rv3 = v;
  endtask

  // Starts at a negedge with the DUT idle; returns at the first idle negedge after the response.
  task automatic do_req(input int d, input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [2:0] f3,
                        input logic [31:0] exp_rd, input logic exp_er, input bit glitch);
    int w, lat, bc, pulses;
    logic [31:0] rd;
    logic er;
    w = (d == 0) ? 0 : 3;
    req_write = wr; req_addr = addr; req_wdata = wd; req_funct3 = f3;
    set_valid(d, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_valid(d, 1'b0);
    lat = -1; bc = 0; pulses = 0; rd = 32'd0; er = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (glitch && i == 1) begin
        req_write = 1'b1; req_wdata = 32'hBAD0BAD0; req_funct3 = 3'b010;
        set_valid(d, 1'b1);
      end
      if (glitch && i == 2) set_valid(d, 1'b0);
      if (get_busy(d)) bc++;
      if (get_rv(d)) begin
        pulses++;
        if (lat < 0) begin
          lat = i; rd = get_rd(d); er = get_er(d);
        end
      end
      if (!get_busy(d) && !get_rv(d)) break;
      @(negedge clk);
    end
    check({tag, ".rdata"}, rd, exp_rd);
    check({tag, ".err"}, 32'(er), 32'(exp_er));
    check({tag, ".latency"}, 32'(lat), 32'(w + 1));
    check({tag, ".busy_cycles"}, 32'(bc), 32'(w + 2));
    check({tag, ".valid_pulses"}, 32'(pulses), 32'd1);
  endtask

  initial begin
    int seen;
    reset = 1'b0; rv0 = 1'b1; rv3 = 1'b1;
    req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h11111111; req_funct3 = 3'b010;
    repeat (3) @(negedge clk);
    check("rst.ready0", 32'(rdy0), 32'd1);
    check("rst.busy0", 32'(busy0), 32'd0);
    check("rst.rspv0", 32'(rspv0), 32'd0);
    check("rst.rdata0", rd0, 32'd0);
    check("rst.err0", 32'(er0), 32'd0);
    check("rst.ready3", 32'(rdy3), 32'd1);
    check("rst.rspv3", 32'(rspv3), 32'd0);
    rv0 = 1'b0; rv3 = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    do_req(0, "sw10",   1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0,        1'b0, 1'b0);
    do_req(0, "lw10",   1'b0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0, 1'b0);
    do_req(0, "sb13",   1'b1, 32'h13, 32'h00000080, 3'b000, 32'h0,        1'b0, 1'b0);
    do_req(0, "lw10b",  1'b0, 32'h10, 32'h0,        3'b010, 32'h80ADBEEF, 1'b0, 1'b0);
    do_req(0, "lb13",   1'b0, 32'h13, 32'h0,        3'b000, 32'hFFFFFF80, 1'b0, 1'b0);
    do_req(0, "lbu13",  1'b0, 32'h13, 32'h0,        3'b100, 32'h00000080, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("hold.rdata", rd0, 32'h00000080);
    do_req(0, "lh12",   1'b0, 32'h12, 32'h0,        3'b001, 32'hFFFF80AD, 1'b0, 1'b0);
    do_req(0, "lhu10",  1'b0, 32'h10, 32'h0,        3'b101, 32'h0000BEEF, 1'b0, 1'b0);

    do_req(0, "sw40",   1'b1, 32'h40, 32'h11223344, 3'b010, 32'h0,        1'b0, 1'b0);
    do_req(0, "sh42",   1'b1, 32'h42, 32'h0000A5B6, 3'b001, 32'h0,        1'b0, 1'b0);
    do_req(0, "lw40",   1'b0, 32'h40, 32'h0,        3'b010, 32'hA5B63344, 1'b0, 1'b0);
    do_req(0, "lh42",   1'b0, 32'h42, 32'h0,        3'b001, 32'hFFFFA5B6, 1'b0, 1'b0);
    do_req(0, "lb41",   1'b0, 32'h41, 32'h0,        3'b000, 32'h00000033, 1'b0, 1'b0);
    do_req(0, "lbu43",  1'b0, 32'h43, 32'h0,        3'b100, 32'h000000A5, 1'b0, 1'b0);

    do_req(0, "sw20",   1'b1, 32'h20, 32'h55667788, 3'b010, 32'h0,        1'b0, 1'b0);
    do_req(0, "st011",  1'b1, 32'h20, 32'h12345678, 3'b011, 32'h0,        1'b1, 1'b0);
    do_req(0, "lw20",   1'b0, 32'h20, 32'h0,        3'b010, 32'h55667788, 1'b0, 1'b0);
    do_req(0, "ld110",  1'b0, 32'h20, 32'h0,        3'b110, 32'h0,        1'b1, 1'b0);
    do_req(0, "lwwrap", 1'b0, 32'h1020, 32'h0,      3'b010, 32'h55667788, 1'b0, 1'b0);

`ifdef DMEM_MISALIGN_CHECK_EN
    do_req(0, "lw11",   1'b0, 32'h11, 32'h0,        3'b010, 32'h0,        1'b1, 1'b0);
    do_req(0, "sh11",   1'b1, 32'h11, 32'h0000FFFF, 3'b001, 32'h0,        1'b1, 1'b0);
    do_req(0, "lw10c",  1'b0, 32'h10, 32'h0,        3'b010, 32'h80ADBEEF, 1'b0, 1'b0);
`else
    do_req(0, "lw11",   1'b0, 32'h11, 32'h0,        3'b010, 32'h80ADBEEF, 1'b0, 1'b0);
    do_req(0, "sh11",   1'b1, 32'h11, 32'h0000FFFF, 3'b001, 32'h0,        1'b0, 1'b0);
    do_req(0, "lw10c",  1'b0, 32'h10, 32'h0,        3'b010, 32'h80ADFFFF, 1'b0, 1'b0);
`endif

    do_req(3, "w3.sw30",  1'b1, 32'h30, 32'h01020304, 3'b010, 32'h0,        1'b0, 1'b0);
    do_req(3, "w3.lw30",  1'b0, 32'h30, 32'h0,        3'b010, 32'h01020304, 1'b0, 1'b0);
    do_req(3, "w3.glit",  1'b0, 32'h30, 32'h0,        3'b010, 32'h01020304, 1'b0, 1'b1);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (rspv3 || !rdy3) seen++;
      @(negedge clk);
    end
    check("w3.glit.no_queue", 32'(seen), 32'd0);
    do_req(3, "w3.lw30b", 1'b0, 32'h30, 32'h0,        3'b010, 32'h01020304, 1'b0, 1'b0);

    // Reset in WAIT, shortly after E2: store must be dropped.
    req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'hCAFEF00D; req_funct3 = 3'b010;
    rv3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rv3 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst.ready", 32'(rdy3), 32'd1);
    check("midrst.busy", 32'(busy3), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rspv3) seen++;
    end
    check("midrst.no_rsp", 32'(seen), 32'd0);
    do_req(3, "midrst.lw30", 1'b0, 32'h30, 32'h0, 3'b010, 32'h01020304, 1'b0, 1'b0);

    // Reset during RESP drops rsp_valid without waiting for a clock.
    req_write = 1'b0; req_addr = 32'h30; req_funct3 = 3'b010;
    rv3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rv3 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rspv3) break;
      @(negedge clk);
    end
    check("resprst.pre_valid", 32'(rspv3), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("resprst.valid", 32'(rspv3), 32'd0);
    check("resprst.ready", 32'(rdy3), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
